// File: rtl/sync_fifo_gen_pkg.sv
// fifo_pkg: shared types and helpers for sync_fifo_gen.
//   addr_w()      - address width for a given depth (clog2, min 1)
//   fifo_mode_e   - read mode selector (STD registered read / FWFT)
//   *_ok()        - parameter legality predicates used by elaboration checks
package fifo_pkg;

  typedef enum logic {STD = 1'b0, FWFT = 1'b1} fifo_mode_e;

  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit afull_ok(input int th, input int depth);
    return (th >= 1) && (th <= depth);
  endfunction

  function automatic bit aempty_ok(input int th, input int depth);
    return (th >= 0) && (th <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_gen_if.sv
// sync_fifo_gen_if: producer/consumer bundle for sync_fifo_gen.
//   master - the user side: drives wdata/wen/ren/err_clr, observes status
//   slave  - the FIFO side: the reverse
//   count is AW+1 bits so it can represent 0..DEPTH.
interface sync_fifo_gen_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int AW = fifo_pkg::addr_w(DEPTH);

  logic [DATA_W-1:0] wdata;
  logic              wen;
  logic              ren;
  logic              err_clr;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [AW:0]       count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wdata, wen, ren, err_clr,
    input  rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wdata, wen, ren, err_clr,
    output rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_gen_ram.sv
// fifo_ram: DATA_W x DEPTH simple dual-port storage.
//   clk          - write clock
//   we/waddr/wdata - synchronous write port
//   raddr/rdata  - asynchronous (combinational) read port
// Not reset: contents are only meaningful between the pointers.
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_gen.sv
// sync_fifo_gen: single-clock parametrised FIFO.
//   clk   - clock, rising edge
//   reset - synchronous, active-low
//   bus   - sync_fifo_gen_if.slave: wdata/wen, ren, err_clr in;
//           rdata/rvalid, full/empty, almost_full/almost_empty, count,
//           sticky overflow/underflow out
// FWFT=0: rdata is a register loaded on an accepted read, rvalid pulses
//         one cycle later. FWFT=1: rdata shows the head word whenever
//         non-empty and ren pops it.
// All status is decoded from the registered count, so full/empty have no
// combinational path from wen/ren.
module sync_fifo_gen #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic          clk,
  input  logic          reset,
  sync_fifo_gen_if.slave bus
);
  import fifo_pkg::*;

  localparam int AW = addr_w(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;

  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_TH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_gen: DEPTH must be a power of two >= 2");
  end
  if (DATA_W < 1) begin : g_bad_width
    $error("sync_fifo_gen: DATA_W must be >= 1");
  end
  if (!afull_ok(AFULL_TH, DEPTH)) begin : g_bad_afull
    $error("sync_fifo_gen: AFULL_TH out of range 1..DEPTH");
  end
  if (!aempty_ok(AEMPTY_TH, DEPTH)) begin : g_bad_aempty
    $error("sync_fifo_gen: AEMPTY_TH out of range 0..DEPTH-1");
  end

  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              full_w, empty_w;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] ram_rdata;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  // Acceptance uses only registered state: a same-cycle read never frees a
  // slot for a write at full, nor does a same-cycle write feed a read at empty.
  assign wr_acc = bus.wen && !full_w;
  assign rd_acc = bus.ren && !empty_w;

  fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr_q[AW-1:0]),
    .wdata (bus.wdata),
    .raddr (rptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    rdata_d  = rdata_q;
    rvalid_d = rd_acc;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (wr_acc) wptr_d = wptr_q + PTR_ONE;
    if (rd_acc) begin
      rptr_d  = rptr_q + PTR_ONE;
      rdata_d = ram_rdata;
    end

    // Pointers carry a wrap bit, so the modular difference is the occupancy.
    count_d = wptr_d - rptr_d;

    // Clear first, then set, so a fresh error in the clearing cycle sticks.
    if (bus.err_clr)              ovf_d = 1'b0;
    if (bus.err_clr)              udf_d = 1'b0;
    if (bus.wen && full_w)        ovf_d = 1'b1;
    if (bus.ren && empty_w)       udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // FWFT presents the head word straight from the array; zero while empty
  // keeps rdata at its reset value when nothing is stored.
  assign bus.rdata  = (MODE == fifo_pkg::FWFT) ? (empty_w ? '0 : ram_rdata) : rdata_q;
  assign bus.rvalid = (MODE == fifo_pkg::FWFT) ? !empty_w : rvalid_q;

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AFULL_C);
  assign bus.almost_empty = (count_q <= AEMPTY_C);
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_gen.sv
// Scoreboard bench: stimulus pushes expected read data, negedge monitors pop
// and compare whenever the DUT presents a word. Status flags are checked
// inline against hand-computed values.
module tb_sync_fifo_gen;
  localparam int DW = 8;
  localparam int DP = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_gen_if #(.DATA_W(DW), .DEPTH(DP)) a_if();
  sync_fifo_gen_if #(.DATA_W(DW), .DEPTH(DP)) b_if();

  sync_fifo_gen #(.DATA_W(DW), .DEPTH(DP), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(0))
    u_std (.clk(clk), .reset(reset), .bus(a_if));
  sync_fifo_gen #(.DATA_W(DW), .DEPTH(DP), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1))
    u_fwft (.clk(clk), .reset(reset), .bus(b_if));

  int checks = 0;
  int failures = 0;
  logic [7:0] qa [$];
  logic [7:0] qb [$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_rst();
    chk("rst_count", a_if.count, 0);
    chk("rst_empty", a_if.empty, 1);
    chk("rst_full", a_if.full, 0);
    chk("rst_aempty", a_if.almost_empty, 1);
    chk("rst_afull", a_if.almost_full, 0);
    chk("rst_rvalid", a_if.rvalid, 0);
    chk("rst_rdata", a_if.rdata, 0);
    chk("rst_ovf", a_if.overflow, 0);
    chk("rst_udf", a_if.underflow, 0);
  endtask

  // Monitors: standard mode pops on every rvalid pulse; FWFT pops on rvalid&&ren.
  always @(negedge clk) begin
    logic [7:0] e;
    if (a_if.rvalid) begin
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL std_unexpected_rvalid actual=%0h required=none", a_if.rdata);
      end else begin
        e = qa.pop_front();
        chk("std_rdata", a_if.rdata, e);
      end
    end
    if (b_if.rvalid && b_if.ren) begin
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL fwft_unexpected_pop actual=%0h required=none", b_if.rdata);
      end else begin
        e = qb.pop_front();
        chk("fwft_rdata", b_if.rdata, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.wen = 0; a_if.ren = 0; a_if.err_clr = 0; a_if.wdata = '0;
    b_if.wen = 0; b_if.ren = 0; b_if.err_clr = 0; b_if.wdata = '0;
    reset = 0;
    cyc(2);
    chk_rst();
    reset = 1;
    cyc();

    // Fill 0x00..0x0F
    a_if.wen = 1;
    for (int i = 0; i < 16; i++) begin
      a_if.wdata = 8'(i);
      qa.push_back(8'(i));
      cyc();
      chk("fill_count", a_if.count, i + 1);
      chk("fill_afull", a_if.almost_full, (i + 1 >= 14) ? 1 : 0);
      chk("fill_full", a_if.full, (i + 1 == 16) ? 1 : 0);
    end
    a_if.wdata = 8'hFF;
    cyc();
    a_if.wen = 0;
    chk("ovf_set", a_if.overflow, 1);
    chk("ovf_count", a_if.count, 16);
    a_if.err_clr = 1; cyc(); a_if.err_clr = 0;
    chk("ovf_clr", a_if.overflow, 0);

    // Drain in standard mode
    a_if.ren = 1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk("drain_count", a_if.count, 15 - i);
      chk("drain_aempty", a_if.almost_empty, (15 - i <= 2) ? 1 : 0);
      chk("drain_empty", a_if.empty, (i == 15) ? 1 : 0);
      chk("drain_rvalid", a_if.rvalid, 1);
    end
    cyc();
    a_if.ren = 0;
    chk("udf_set", a_if.underflow, 1);
    chk("udf_rvalid", a_if.rvalid, 0);
    chk("udf_rdata_hold", a_if.rdata, 8'h0F);
    a_if.err_clr = 1; cyc(); a_if.err_clr = 0;

    // Steady read/write at count 8 across pointer wrap
    a_if.wen = 1;
    for (int i = 0; i < 8; i++) begin
      a_if.wdata = 8'(8'h40 + i); qa.push_back(8'(8'h40 + i)); cyc();
    end
    a_if.ren = 1;
    for (int i = 0; i < 40; i++) begin
      a_if.wdata = 8'(8'h48 + i); qa.push_back(8'(8'h48 + i));
      cyc();
      chk("steady_count", a_if.count, 8);
      chk("steady_flags", {a_if.full, a_if.empty, a_if.almost_full, a_if.almost_empty,
                           a_if.overflow, a_if.underflow}, 0);
    end
    a_if.wen = 0;
    cyc(8);
    a_if.ren = 0;
    chk("steady_drained", a_if.empty, 1);

    // Full with wen+ren: read accepted, write rejected
    a_if.wen = 1;
    for (int i = 0; i < 16; i++) begin
      a_if.wdata = 8'(8'h80 + i); qa.push_back(8'(8'h80 + i)); cyc();
    end
    a_if.wdata = 8'hEE; a_if.ren = 1;
    cyc();
    a_if.wen = 0; a_if.ren = 0;
    chk("fullrw_count", a_if.count, 15);
    chk("fullrw_ovf", a_if.overflow, 1);
    a_if.ren = 1; cyc(15); a_if.ren = 0;
    chk("fullrw_drained", a_if.empty, 1);
    a_if.err_clr = 1; cyc(); a_if.err_clr = 0;

    // Empty with wen+ren: write accepted, read rejected
    a_if.wen = 1; a_if.ren = 1; a_if.wdata = 8'h5A; qa.push_back(8'h5A);
    cyc();
    a_if.wen = 0; a_if.ren = 0;
    chk("emptyrw_count", a_if.count, 1);
    chk("emptyrw_udf", a_if.underflow, 1);
    chk("emptyrw_rvalid", a_if.rvalid, 0);

    // err_clr with a same-cycle new underflow
    a_if.ren = 1; cyc();
    a_if.err_clr = 1; cyc();
    a_if.ren = 0;
    chk("clr_vs_set", a_if.underflow, 1);
    cyc();
    a_if.err_clr = 0;
    chk("clr_only", a_if.underflow, 0);

    // Reset at count 9 with a read in flight
    a_if.wen = 1;
    for (int i = 0; i < 9; i++) begin
      a_if.wdata = 8'(8'h10 + i); cyc();
    end
    a_if.wen = 0;
    chk("pre_rst_count", a_if.count, 9);
    qa.push_back(8'h10);
    a_if.ren = 1; cyc();
    chk("pre_rst_count2", a_if.count, 8);
    reset = 0; cyc();
    chk_rst();
    a_if.ren = 0; reset = 1; cyc();
    a_if.wen = 1; a_if.wdata = 8'h3C; qa.push_back(8'h3C); cyc();
    a_if.wen = 0; a_if.ren = 1; cyc();
    a_if.ren = 0;
    chk("post_rst_rvalid", a_if.rvalid, 1);
    chk("post_rst_rdata", a_if.rdata, 8'h3C);
    cyc();

    // FWFT mode
    b_if.wen = 1; b_if.wdata = 8'hA5; qb.push_back(8'hA5); cyc();
    b_if.wen = 0;
    chk("fwft_rvalid", b_if.rvalid, 1);
    chk("fwft_head", b_if.rdata, 8'hA5);
    cyc();
    chk("fwft_hold_count", b_if.count, 1);
    b_if.ren = 1; cyc(); b_if.ren = 0;
    chk("fwft_pop_empty", b_if.empty, 1);
    chk("fwft_pop_rvalid", b_if.rvalid, 0);
    b_if.wen = 1;
    b_if.wdata = 8'h11; qb.push_back(8'h11); cyc();
    b_if.wdata = 8'h22; qb.push_back(8'h22); cyc();
    b_if.wen = 0;
    chk("fwft_count2", b_if.count, 2);
    b_if.ren = 1; cyc(2); b_if.ren = 0;
    chk("fwft_drained", b_if.empty, 1);

    cyc(2);
    chk("scoreboard_empty", qa.size() + qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sync_fifo_gen.md
# sync_fifo_gen

Single-clock, parametrised FIFO; successor to the dual-clock FIFO for paths where producer and consumer share a clock. Generalises data width and depth independently and adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. Sits between any producer/consumer pair in the `clk` domain. No gray coding or synchronisers.

## Interface
- `DATA_W`, default 8: data width in bits, ≥1.
- `DEPTH`, default 16: number of entries; power of two, ≥2.
- `AFULL_TH`, default DEPTH-2: `almost_full` asserts when count ≥ AFULL_TH; range 1..DEPTH.
- `AEMPTY_TH`, default 2: `almost_empty` asserts when count ≤ AEMPTY_TH; range 0..DEPTH-1.
- `FWFT`, default 0: 0 = standard registered read; 1 = first-word-fall-through.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `wdata` in DATA_W: write data.
- `wen` in 1: write request.
- `ren` in 1: read request (standard mode) or pop (FWFT mode).
- `err_clr` in 1: clears the sticky error flags.
- `rdata` out DATA_W: read data.
- `rvalid` out 1: `rdata` is valid this cycle.
- `full` out 1: FIFO is full.
- `empty` out 1: FIFO is empty.
- `almost_full` out 1: occupancy at or above AFULL_TH.
- `almost_empty` out 1: occupancy at or below AEMPTY_TH.
- `count` out AW+1: occupancy, 0..DEPTH. AW = clog2(DEPTH).
- `overflow` out 1: sticky; a write was attempted while full.
- `underflow` out 1: sticky; a read was attempted while empty.

## Operation
- Pointers `wptr` and `rptr` are AW+1 bits; the MSB is the wrap bit.
  - Memory address = low AW bits.
  - `count` = wptr − rptr, modulo 2^(AW+1).
- Write accepted iff `wen && !full`. The accepted write stores `wdata` at `wptr` and increments `wptr`.
- Read accepted iff `ren && !empty`. The accepted read increments `rptr`.
- Simultaneous accepted read and write: both take effect and `count` is unchanged.
- Boundary: at full, `wen` is rejected even when a read is accepted in the same cycle. At empty, `ren` is rejected even when a write is accepted in the same cycle.
- Rejected `wen`: memory and pointers are unchanged; `overflow` is set. Rejected `ren`: pointers and `rdata` are unchanged; `underflow` is set.
- `overflow` and `underflow` hold until `err_clr` is high at a clock edge. If clear and a new set occur in the same cycle, set wins.
- Flags are decoded from registered `count`:
  - `full` = (count==DEPTH)
  - `empty` = (count==0)
  - `almost_full` = (count≥AFULL_TH)
  - `almost_empty` = (count≤AEMPTY_TH)
- Standard mode (FWFT=0):
  - `rdata` is a register, loaded with mem[rptr] on an accepted read.
  - `rvalid` is a one-cycle pulse in the cycle after an accepted read.
  - When no read is accepted, `rdata` holds its last value.
- FWFT mode (FWFT=1):
  - `rdata` = mem[rptr] whenever `empty` is 0.
  - `rvalid` = !empty.
  - `ren` acknowledges (pops) the current word.
- Pointer wrap-around is natural modulo 2^(AW+1); there is no special case at the wrap.
- Reset mid-operation: pointers, count, `rdata` and the flags return to their reset values on that edge. Contents are discarded and any pending `rvalid` is dropped. Memory array contents are not reset.

## Timing
- Reset values: `count`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0, `rvalid`=0, `rdata`=0, `overflow`=0, `underflow`=0.
- Write→`empty` deassert: 1 cycle (visible after the write edge).
- Standard mode: write at edge N; earliest accepted read at edge N+1; data on `rdata` with `rvalid`=1 after edge N+1.
- FWFT mode: write at edge N; `rdata`/`rvalid` valid after edge N, with no read needed.
- Back-to-back: one write and one read per cycle sustained, with no bubbles.
- All flags and `count` change only at clock edges. `full`/`empty` have no combinational path from `wen`/`ren`.

## Structure
- Package `fifo_pkg` holds:
  - function `addr_w(depth)` (clog2);
  - enum `fifo_mode_e {STD, FWFT}`;
  - parameter-legality checks (power-of-two depth, threshold ranges) as elaboration assertions.
- Sub-module `fifo_ram`: DATA_W×DEPTH single-clock simple dual-port array. It has a synchronous write port and an asynchronous read port, and is not reset. The top level owns pointers, count, flags and read-mode logic.

## Test plan
- Reset, then fill: DEPTH=16, write 0x00..0x0F.
  - `count` steps 1..16.
  - `almost_full` rises at count 14; `full` rises at 16.
  - 17th write → `overflow`=1, `count` stays 16.
- Drain in standard mode: 16 reads return 0x00..0x0F, each with a 1-cycle `rvalid` pulse.
  - `almost_empty` rises at count 2; `empty` at 0.
  - Extra read → `underflow`=1, `rdata` holds 0x0F.
- Simultaneous read/write at count 8 for 40 cycles: `count` stays 8, data order is preserved across pointer wrap, and no flags toggle.
- FWFT=1: write 0xA5 into the empty FIFO → next cycle `rvalid`=1, `rdata`=0xA5 without `ren`; `ren` → `empty`=1 next cycle.
- Boundary cases:
  - Full plus `wen`+`ren`: read accepted, write rejected, `count`=15, `overflow`=1.
  - Empty plus `wen`+`ren`: write accepted, read rejected, `count`=1, `underflow`=1.
  - `err_clr` with a same-cycle new error: flag stays set.
- Reset at count 9 with a read in flight: after the edge, all outputs are at reset values and `rvalid`=0. Subsequent writes of 0x3C then a read return 0x3C.
